// File: rtl/vga_pkg.sv
// Shared framebuffer definitions: default bus widths and the host holding-register
// state encoding used by the arbiter slice.
package vga_pkg;

    localparam int ADDR_W_DEF = 19;   // 640x480 = 307200 words
    localparam int DATA_W_DEF = 12;   // RGB444

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its environment (video fetch,
// host write port, memory port and starvation flag).
interface vga_fb_arbiter_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              FETCH_REQ;
    logic [ADDR_W-1:0] FETCH_ADDR;
    logic [DATA_W-1:0] PIX_DATA;
    logic              PIX_VALID;

    logic              HOST_VALID;
    logic              HOST_READY;
    logic [ADDR_W-1:0] HOST_ADDR;
    logic [DATA_W-1:0] HOST_DATA;

    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    logic              STARVE;
    logic              STARVE_CLR;

    modport master (
        output FETCH_REQ, FETCH_ADDR, HOST_VALID, HOST_ADDR, HOST_DATA, MEM_RDATA, STARVE_CLR,
        input  PIX_DATA, PIX_VALID, HOST_READY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, STARVE
    );

    modport slave (
        input  FETCH_REQ, FETCH_ADDR, HOST_VALID, HOST_ADDR, HOST_DATA, MEM_RDATA, STARVE_CLR,
        output PIX_DATA, PIX_VALID, HOST_READY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, STARVE
    );

endinterface

// File: rtl/vga_fb_holdreg.sv
// One-entry host write holding register with a registered ready/empty handshake.
// The word is drained by the arbiter on the first cycle video leaves the memory idle.
module vga_fb_holdreg
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK_50M,
    input  logic              RST,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              drain,
    output logic              host_ready,
    output logic              pend,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] hold_data
);

    hold_state_t state, state_nxt;
    logic        take;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state      <= EMPTY;
            host_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            host_ready <= (state_nxt == EMPTY);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            EMPTY: begin
                if (host_valid && host_ready) begin
                    take      = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (drain) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: the holding data is reset too, so a discarded word never leaks onto MEM_WDATA.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (take) begin
            hold_addr <= host_addr;
            hold_data <= host_data;
        end
    end

    assign pend = (state == PEND);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: video fetches own the memory, host writes drain from a
// one-entry buffer in idle cycles. Starvation monitor built only with VGA_FB_ARB_STARVE_EN.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int STALL_MAX = 800
) (
    input logic             CLK_50M,
    input logic             RST,
    vga_fb_arbiter_if.slave bus
);

    logic              fetch;
    logic              drain;
    logic              pend;
    logic              rd_d1;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    assign fetch = bus.FETCH_REQ;
    assign drain = pend && !bus.FETCH_REQ;

    vga_fb_holdreg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_holdreg (
        .CLK_50M    (CLK_50M),
        .RST        (RST),
        .host_valid (bus.HOST_VALID),
        .host_addr  (bus.HOST_ADDR),
        .host_data  (bus.HOST_DATA),
        .drain      (drain),
        .host_ready (bus.HOST_READY),
        .pend       (pend),
        .hold_addr  (hold_addr),
        .hold_data  (hold_data)
    );

    // Fetch and drain are mutually exclusive, so MEM_WE is simply the drain strobe.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            bus.MEM_EN    <= 1'b0;
            bus.MEM_WE    <= 1'b0;
            bus.MEM_ADDR  <= '0;
            bus.MEM_WDATA <= '0;
        end else begin
            bus.MEM_EN <= fetch || drain;
            bus.MEM_WE <= drain;
            if (fetch) begin
                bus.MEM_ADDR <= bus.FETCH_ADDR;
            end else if (drain) begin
                bus.MEM_ADDR  <= hold_addr;
                bus.MEM_WDATA <= hold_data;
            end
        end
    end

    // Read data returns one cycle after the strobe and is captured one cycle later.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            rd_d1         <= 1'b0;
            bus.PIX_VALID <= 1'b0;
            bus.PIX_DATA  <= '0;
        end else begin
            rd_d1         <= bus.MEM_EN && !bus.MEM_WE;
            bus.PIX_VALID <= rd_d1;
            if (rd_d1) bus.PIX_DATA <= bus.MEM_RDATA;
        end
    end

`ifdef VGA_FB_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    logic [CNT_W-1:0] stall_cnt, stall_nxt;
    logic             starve_set;

    always_comb begin
        stall_nxt = stall_cnt;
        if (drain) begin
            stall_nxt = '0;
        end else if (pend && fetch && (stall_cnt != CNT_W'(STALL_MAX))) begin
            stall_nxt = stall_cnt + CNT_W'(1);
        end
    end

    // Keeps re-asserting while saturated, so a clear during ongoing starvation loses.
    assign starve_set = pend && fetch && (stall_nxt == CNT_W'(STALL_MAX));

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            stall_cnt  <= '0;
            bus.STARVE <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            if (starve_set)          bus.STARVE <= 1'b1;
            else if (bus.STARVE_CLR) bus.STARVE <= 1'b0;
        end
    end
`else
    logic unused_starve_clr;
    assign unused_starve_clr = bus.STARVE_CLR;
    assign bus.STARVE        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: reset, fetch burst, host write table and
// starvation sequence; expectations follow VGA_FB_ARB_STARVE_EN when defined.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int AW   = 19;
    localparam int DW   = 12;
    localparam int SMAX = 8;
`ifdef VGA_FB_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic CLK_50M = 1'b0;
    logic RST     = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STALL_MAX (SMAX)
    ) dut (
        .CLK_50M (CLK_50M),
        .RST     (RST),
        .bus     (bus)
    );

    always #10 CLK_50M = ~CLK_50M;

    // Memory model: synchronous, read data valid one cycle after the strobe.
    logic [DW-1:0] mem     [1024];
    bit            written [1024];

    function automatic logic [DW-1:0] init_word(int a);
        return DW'(a * 37 + 5);
    endfunction

    always @(posedge CLK_50M) begin
        if (bus.MEM_EN && bus.MEM_WE) begin
            mem[bus.MEM_ADDR[9:0]]     <= bus.MEM_WDATA;
            written[bus.MEM_ADDR[9:0]] <= 1'b1;
        end else if (bus.MEM_EN) begin
            bus.MEM_RDATA <= written[bus.MEM_ADDR[9:0]] ? mem[bus.MEM_ADDR[9:0]]
                                                         : init_word(int'(bus.MEM_ADDR[9:0]));
        end
    end

    typedef struct {
        bit          f;
        logic [31:0] fa;
        bit          hv;
        logic [31:0] ha;
        logic [31:0] hd;
        bit          en;
        bit          we;
        logic [31:0] a;
        logic [31:0] w;
        bit          rdy;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input bit f, input int fa, input bit hv, input int ha, input int hd,
                         input bit clr);
        bus.FETCH_REQ  = f;
        bus.FETCH_ADDR = AW'(fa);
        bus.HOST_VALID = hv;
        bus.HOST_ADDR  = AW'(ha);
        bus.HOST_DATA  = DW'(hd);
        bus.STARVE_CLR = clr;
    endtask

    task automatic tick;
        @(posedge CLK_50M);
        #1;
    endtask

    // Assert reset mid-cycle and release it mid-cycle, leaving inputs idle.
    task automatic reset_pulse;
        drive(0, 0, 0, 0, 0, 0);
        #4 RST = 1'b1;
        #5 RST = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 32'h000, 0, 32'h000, 32'h000, 0, 0, 32'h000, 32'h000, 1};
        tbl[1]  = '{0, 32'h000, 1, 32'h100, 32'hABC, 0, 0, 32'h000, 32'h000, 0};
        tbl[2]  = '{0, 32'h000, 0, 32'h000, 32'h000, 1, 1, 32'h100, 32'hABC, 1};
        tbl[3]  = '{0, 32'h000, 0, 32'h000, 32'h000, 0, 0, 32'h100, 32'hABC, 1};
        tbl[4]  = '{1, 32'h005, 1, 32'h200, 32'h123, 1, 0, 32'h005, 32'hABC, 0};
        tbl[5]  = '{1, 32'h006, 1, 32'h200, 32'h456, 1, 0, 32'h006, 32'hABC, 0};
        tbl[6]  = '{1, 32'h007, 0, 32'h000, 32'h000, 1, 0, 32'h007, 32'hABC, 0};
        tbl[7]  = '{1, 32'h008, 0, 32'h000, 32'h000, 1, 0, 32'h008, 32'hABC, 0};
        tbl[8]  = '{1, 32'h009, 0, 32'h000, 32'h000, 1, 0, 32'h009, 32'hABC, 0};
        tbl[9]  = '{0, 32'h000, 0, 32'h000, 32'h000, 1, 1, 32'h200, 32'h123, 1};
        tbl[10] = '{1, 32'h010, 1, 32'h300, 32'h7E5, 1, 0, 32'h010, 32'h123, 0};
        tbl[11] = '{0, 32'h000, 1, 32'h3FF, 32'h111, 1, 1, 32'h300, 32'h7E5, 1};
        tbl[12] = '{0, 32'h000, 1, 32'h3FF, 32'h111, 0, 0, 32'h300, 32'h7E5, 0};
        tbl[13] = '{0, 32'h000, 0, 32'h000, 32'h000, 1, 1, 32'h3FF, 32'h111, 1};
        tbl[14] = '{0, 32'h000, 0, 32'h000, 32'h000, 0, 0, 32'h3FF, 32'h111, 1};

        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        #5 RST = 1'b0;
        tick();
        check("ready_after_first_reset", 32'(bus.HOST_READY), 32'd1);

        // Reset in the middle of a fetch burst
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, 0, 0, 0, 0);
            tick();
        end
        check("pre_reset_mem_en", 32'(bus.MEM_EN), 32'd1);
        check("pre_reset_pix_valid", 32'(bus.PIX_VALID), 32'd1);
        #4 RST = 1'b1;
        #1;
        check("rst_mem_en", 32'(bus.MEM_EN), 32'd0);
        check("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
        check("rst_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
        check("rst_mem_wdata", 32'(bus.MEM_WDATA), 32'd0);
        check("rst_pix_data", 32'(bus.PIX_DATA), 32'd0);
        check("rst_pix_valid", 32'(bus.PIX_VALID), 32'd0);
        check("rst_host_ready", 32'(bus.HOST_READY), 32'd0);
        check("rst_starve", 32'(bus.STARVE), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        #5 RST = 1'b0;
        #1;
        check("ready_low_before_edge", 32'(bus.HOST_READY), 32'd0);
        tick();
        check("ready_after_release", 32'(bus.HOST_READY), 32'd1);
        check("no_stale_pix_1", 32'(bus.PIX_VALID), 32'd0);
        check("idle_mem_en", 32'(bus.MEM_EN), 32'd0);
        tick();
        check("no_stale_pix_2", 32'(bus.PIX_VALID), 32'd0);

        // 640-word fetch burst, then two drain cycles for the pixel pipeline
        for (int c = 0; c < 642; c++) begin
            drive(c < 640, c, 0, 0, 0, 0);
            tick();
            if (c < 640) begin
                check("burst_mem_en", 32'(bus.MEM_EN), 32'd1);
                check("burst_mem_we", 32'(bus.MEM_WE), 32'd0);
                check("burst_mem_addr", 32'(bus.MEM_ADDR), 32'(c));
            end else begin
                check("burst_end_mem_en", 32'(bus.MEM_EN), 32'd0);
            end
            if (c < 2) begin
                check("burst_pix_latency", 32'(bus.PIX_VALID), 32'd0);
            end else begin
                check("burst_pix_valid", 32'(bus.PIX_VALID), 32'd1);
                check("burst_pix_data", 32'(bus.PIX_DATA), 32'(init_word(c - 2)));
            end
        end
        tick();
        check("burst_pix_done", 32'(bus.PIX_VALID), 32'd0);

        // Host write / collision vector table
        reset_pulse();
        for (int r = 0; r < 15; r++) begin
            drive(tbl[r].f, int'(tbl[r].fa), tbl[r].hv, int'(tbl[r].ha), int'(tbl[r].hd), 0);
            tick();
            check($sformatf("tbl%0d_mem_en", r), 32'(bus.MEM_EN), 32'(tbl[r].en));
            check($sformatf("tbl%0d_mem_we", r), 32'(bus.MEM_WE), 32'(tbl[r].we));
            check($sformatf("tbl%0d_mem_addr", r), 32'(bus.MEM_ADDR), tbl[r].a);
            check($sformatf("tbl%0d_mem_wdata", r), 32'(bus.MEM_WDATA), tbl[r].w);
            check($sformatf("tbl%0d_host_ready", r), 32'(bus.HOST_READY), 32'(tbl[r].rdy));
        end

        // Starvation: host word pending behind a long fetch run
        reset_pulse();
        tick();
        drive(1, 32'h20, 1, 32'h50, 32'h0F0, 0);
        tick();
        check("starve_accept_ready", 32'(bus.HOST_READY), 32'd0);
        for (int i = 1; i <= SMAX; i++) begin
            drive(1, 32'h20 + i, 0, 0, 0, 0);
            tick();
            check($sformatf("starve_run%0d", i), 32'(bus.STARVE), 32'(STARVE_ON && (i >= SMAX)));
            check($sformatf("starve_run%0d_we", i), 32'(bus.MEM_WE), 32'd0);
        end
        drive(1, 32'h30, 0, 0, 0, 1);
        tick();
        check("starve_set_beats_clr", 32'(bus.STARVE), 32'(STARVE_ON));
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("starve_sticky_on_drain", 32'(bus.STARVE), 32'(STARVE_ON));
        check("starve_drain_we", 32'(bus.MEM_WE), 32'd1);
        check("starve_drain_addr", 32'(bus.MEM_ADDR), 32'h50);
        check("starve_drain_wdata", 32'(bus.MEM_WDATA), 32'h0F0);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("starve_cleared", 32'(bus.STARVE), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, framebuffer word-address width (640x480 = 307200 words).
REQ-002 SHALL have parameter DATA_W, default 12, pixel word width (RGB444).
REQ-003 SHALL have parameter STALL_MAX, default 800, consecutive host-stall cycles before STARVE is flagged.
REQ-004 SHALL have port CLK_50M  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port FETCH_REQ  input  1  video fetch request, one word per asserted cycle.
REQ-007 SHALL have port FETCH_ADDR  input  ADDR_W  video fetch address, qualified by FETCH_REQ.
REQ-008 SHALL have port PIX_DATA  output  DATA_W  fetched pixel word.
REQ-009 SHALL have port PIX_VALID  output  1  PIX_DATA valid this cycle.
REQ-010 SHALL have port HOST_VALID  input  1  host write offered.
REQ-011 SHALL have port HOST_READY  output  1  host write accepted when HOST_VALID is also high.
REQ-012 SHALL have port HOST_ADDR  input  ADDR_W  host write address.
REQ-013 SHALL have port HOST_DATA  input  DATA_W  host write data.
REQ-014 SHALL have port MEM_EN  output  1  memory access strobe.
REQ-015 SHALL have port MEM_WE  output  1  1 = write, 0 = read; meaningful only with MEM_EN.
REQ-016 SHALL have port MEM_ADDR  output  ADDR_W  memory address.
REQ-017 SHALL have port MEM_WDATA  output  DATA_W  memory write data.
REQ-018 SHALL have port MEM_RDATA  input  DATA_W  memory read data, valid one cycle after a read strobe.
REQ-019 SHALL have port STARVE  output  1  sticky host-starvation flag.
REQ-020 SHALL have port STARVE_CLR  input  1  clears STARVE.

Function
REQ-021 SHALL grant the memory to video whenever FETCH_REQ is high; video has absolute priority.
REQ-022 SHALL, for FETCH_REQ sampled at edge k, register MEM_EN=1, MEM_WE=0, MEM_ADDR=FETCH_ADDR at edge k, and register PIX_DATA=MEM_RDATA and PIX_VALID=1 at edge k+2 (fixed 2-cycle latency, back-to-back fetches every cycle).
REQ-023 SHALL contain a one-entry host holding register; HOST_READY = holding register empty (registered, not dependent on HOST_VALID).
REQ-024 SHALL load HOST_ADDR/HOST_DATA into the holding register on a cycle with HOST_VALID and HOST_READY high.
REQ-025 SHALL use FSM states EMPTY (holding empty) and PEND (holding full): EMPTY->PEND on host transfer; PEND->EMPTY on drain; PEND holds otherwise.
REQ-026 SHALL drain PEND on the first cycle with FETCH_REQ low, registering MEM_EN=1, MEM_WE=1, MEM_ADDR/MEM_WDATA from the holding register.
REQ-027 SHALL NOT accept a new host word in the cycle the holding register drains; HOST_READY rises the cycle after the drain.
REQ-028 SHALL drive MEM_EN=0 on cycles with neither a fetch nor a drain; MEM_ADDR/MEM_WDATA hold their last values.
REQ-029 SHALL count consecutive cycles in PEND with FETCH_REQ high (saturating at STALL_MAX); on reaching STALL_MAX set STARVE; counter clears on drain.
REQ-030 SHALL clear STARVE on STARVE_CLR; simultaneous set and clear resolve to set.

Reset
REQ-031 SHALL, on RST, asynchronously force FSM=EMPTY, HOST_READY=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, PIX_DATA=0, PIX_VALID=0, STARVE=0, stall counter=0.
REQ-032 SHALL raise HOST_READY at the first edge after RST deasserts; a pending host word or in-flight fetch at reset is discarded.

Configuration
REQ-033 SHALL compile the stall counter and STARVE logic only when VGA_FB_ARB_STARVE_EN is defined; without it STARVE is tied 0, STARVE_CLR ignored, all other behaviour identical.

Structure
REQ-034 SHALL take ADDR_W/DATA_W defaults and the FSM state encoding from shared package vga_pkg.
REQ-035 SHALL implement the holding register plus handshake as sub-module vga_fb_holdreg; arbitration and pipeline stay in the top.

Verification
REQ-036 Reset: RST=1 mid-fetch burst -> all outputs 0 immediately; HOST_READY=1 one edge after release.
REQ-037 Fetch burst: FETCH_REQ 640 cycles, addr 0..639 -> 640 MEM reads in order, PIX_VALID 640 cycles starting 2 cycles later, PIX_DATA matches memory model.
REQ-038 Host write idle: HOST_VALID with addr 0x100, data 0xABC, no fetch -> MEM_EN=1, MEM_WE=1, addr 0x100, data 0xABC one cycle after acceptance.
REQ-039 Collision: host word pending while FETCH_REQ high 5 cycles -> write issued cycle after FETCH_REQ falls; no fetch lost or delayed.
REQ-040 Starvation (macro on, STALL_MAX=8): pending host, FETCH_REQ high 8 cycles -> STARVE=1; STARVE_CLR -> 0; macro off -> STARVE stays 0.
